// File: rtl/cmp_operand_loader.sv
// Operand loader for the magnitude comparator: synchronises switches and buttons, turns each
// press into a one-cycle load, and holds a stable A/B pair. Optional debounce: CMP_LOADER_DEBOUNCE_EN.
module cmp_operand_loader #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_a,
  input  logic             btn_b,
  input  logic             btn_clr,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             a_loaded,
  output logic             b_loaded,
  output logic             valid,
  output logic             new_pair
);

  // Bit 1 means A is loaded, bit 0 means B is loaded, so the flags decode straight from the state flops.
  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    B_ONLY = 2'b01,
    A_ONLY = 2'b10,
    BOTH   = 2'b11
  } state_t;

  localparam int BTN_A   = 0;
  localparam int BTN_B   = 1;
  localparam int BTN_CLR = 2;

  logic [2:0]                        btn_raw;
  logic [SYNC_STAGES-1:0][2:0]       btn_sync;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sw_sync;
  logic [2:0]                        btn_lvl;
  logic [2:0]                        btn_dly;
  logic [2:0]                        btn_pulse;
  logic [WIDTH-1:0]                  sw_cap;

  assign btn_raw = {btn_clr, btn_b, btn_a};

  // Switches and buttons share one chain depth so the captured switch value lines up with the press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync <= '0;
      sw_sync  <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous stage's old value,
      // which is what makes this a shift chain rather than a single flop.
      btn_sync[0] <= btn_raw;
      sw_sync[0]  <= sw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        btn_sync[i] <= btn_sync[i-1];
        sw_sync[i]  <= sw_sync[i-1];
      end
    end
  end

`ifdef CMP_LOADER_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [2:0]                            btn_filt;
  logic [2:0][CW-1:0]                    db_cnt;
  logic [DEBOUNCE_CYCLES-1:0][WIDTH-1:0] sw_dly;

  // The filtered level follows the synchronised level only after it has disagreed for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement in between restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_filt <= '0;
      db_cnt   <= '0;
      sw_dly   <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (btn_sync[SYNC_STAGES-1][i] != btn_filt[i]) begin
          if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            btn_filt[i] <= btn_sync[SYNC_STAGES-1][i];
            db_cnt[i]   <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
      sw_dly[0] <= sw_sync[SYNC_STAGES-1];
      for (int i = 1; i < DEBOUNCE_CYCLES; i++) begin
        sw_dly[i] <= sw_dly[i-1];
      end
    end
  end

  assign btn_lvl = btn_filt;
  assign sw_cap  = sw_dly[DEBOUNCE_CYCLES-1];
`else
  assign btn_lvl = btn_sync[SYNC_STAGES-1];
  assign sw_cap  = sw_sync[SYNC_STAGES-1];
`endif

  // The delayed copy resets to 0, so a button held through reset release still registers as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_dly <= '0;
    end else begin
      btn_dly <= btn_lvl;
    end
  end

  assign btn_pulse = btn_lvl & ~btn_dly;

  state_t state;
  state_t state_nxt;
  logic   ld_a;
  logic   ld_b;
  logic   clr;

  assign ld_a = btn_pulse[BTN_A];
  assign ld_b = btn_pulse[BTN_B];
  assign clr  = btn_pulse[BTN_CLR];

  // A load only ever adds to the loaded set; clear is handled separately and wins.
  always_comb begin
    state_nxt = state_t'({state[1] | ld_a, state[0] | ld_b});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      a        <= '0;
      b        <= '0;
      new_pair <= 1'b0;
    end else begin
      new_pair <= 1'b0;
      if (clr) begin
        state <= EMPTY;
        a     <= '0;
        b     <= '0;
      end else if (ld_a || ld_b) begin
        if (ld_a) a <= sw_cap;
        if (ld_b) b <= sw_cap;
        state    <= state_nxt;
        new_pair <= (state_nxt == BOTH);
      end
    end
  end

  assign a_loaded = state[1];
  assign b_loaded = state[0];
  assign valid    = (state == BOTH);

endmodule

// File: doc/cmp_operand_loader.md
# cmp_operand_loader

- Captures two WIDTH-bit operands from a shared switch bus, one per push-button, and holds them as a stable pair for the magnitude comparator stage downstream.
- Synchronises the buttons and switches to the clock and turns each button press into a single-cycle load.
- Tracks which operands are loaded and flags when a complete pair is valid.
- Sits between the board I/O and the comparator; its `a`/`b` outputs drive the comparator inputs directly.

## Interface
- `WIDTH`, default 4: operand width.
- `SYNC_STAGES`, default 2: synchroniser flop depth for every input; minimum 2.
- `DEBOUNCE_CYCLES`, default 16: stable-cycle count; used only when `CMP_LOADER_DEBOUNCE_EN` is defined.
- `clk` input 1: single clock; all flops on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `sw` input WIDTH: raw switch bus, asynchronous.
- `btn_a` input 1: raw button; a press loads operand A.
- `btn_b` input 1: raw button; a press loads operand B.
- `btn_clr` input 1: raw button; a press clears both operands.
- `a` output WIDTH: registered operand A.
- `b` output WIDTH: registered operand B.
- `a_loaded` output 1: A holds a captured value.
- `b_loaded` output 1: B holds a captured value.
- `valid` output 1: both operands loaded (state BOTH).
- `new_pair` output 1: one-cycle pulse when the pair becomes valid or changes while valid.

## Operation
- **Synchronisers:** `sw`, `btn_a`, `btn_b` and `btn_clr` each pass through a SYNC_STAGES-deep flop chain.
  - Switch and button paths have equal depth, so captured `sw` is aligned with the press.
- **Edge detect:** a press is a 0→1 transition of a synchronised button, detected against a one-flop delayed copy. It yields exactly one pulse per press, however long the button is held.
- **State machine:** states EMPTY, A_ONLY, B_ONLY, BOTH.
  - `a_loaded` is 1 in A_ONLY and BOTH.
  - `b_loaded` is 1 in B_ONLY and BOTH.
  - `valid` is 1 only in BOTH.
- **Transitions:**
  - EMPTY + A pulse → A_ONLY.
  - EMPTY + B pulse → B_ONLY.
  - A_ONLY + B pulse → BOTH.
  - B_ONLY + A pulse → BOTH.
  - Reloading an already-loaded operand updates its value and keeps the state.
- **Loading:** an A pulse writes synchronised `sw` into `a`; a B pulse writes it into `b`.
- **Simultaneous A and B pulses:** both registers take the same `sw` value and the next state is BOTH, from any state.
- **Clear:** a clear pulse sets `a = 0`, `b = 0` and state EMPTY. It overrides any A/B pulse in the same cycle.
- **`new_pair`:** pulses for one cycle on the cycle after any load that leaves the state in BOTH.
  - This covers entering BOTH and every reload while in BOTH, including a reload with an identical value.
  - It never pulses on clear.

## Timing
- **Reset values:** all outputs 0, state EMPTY, all synchroniser, delay and debounce flops 0.
- **Button held through reset release:** the press is seen as a rising edge and loads normally. This is intended behaviour.
- **Load latency:** the register updates on rising edge SYNC_STAGES+1, counted from the first edge that samples the raw button high. With the default of 2, `a`/`b` change on the 3rd edge.
- **Outputs:** `a_loaded`, `b_loaded` and `valid` change on the same edge as the register. `new_pair` is high during the cycle following that edge.
- **Stable window:** `sw` must be stable from one cycle before the press until SYNC_STAGES+1 cycles after it. The captured value is whatever the synchronised `sw` shows on the load edge.
- **No handshake with the comparator:** `a`/`b` are held constant between loads, and downstream logic samples them whenever `valid` = 1.
- **Mid-operation reset:** aborts any pending edge or debounce count. No load completes after `rst_n` deasserts unless a new rising edge is detected.

## Configuration
- **`CMP_LOADER_DEBOUNCE_EN` defined:** each synchronised button feeds a counter.
  - The filtered level changes only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
  - Edge detection runs on the filtered level, so load latency becomes SYNC_STAGES+1+DEBOUNCE_CYCLES edges.
  - The switch path is delayed by the same DEBOUNCE_CYCLES so that it stays aligned with the button.
- **Macro undefined:** there is no counter, edge detection runs directly on the synchronised level, and DEBOUNCE_CYCLES is ignored.

## Test plan
- Reset, then set `sw=4'hA` and press `btn_a` for 5 cycles:
  - `a=4'hA` on edge 3.
  - `a_loaded=1`, `valid=0`.
  - Exactly one load occurs, with `b=0`.
- Continue with `sw=4'h3` and press `btn_b`:
  - `b=4'h3`, `valid=1`.
  - `new_pair` is high for exactly 1 cycle.
  - The comparator sees a > b.
- With `valid=1`, set `sw=4'h3` and press `btn_a`:
  - `a=4'h3`, state stays BOTH, `new_pair` pulses once.
- Press `btn_a` and `btn_b` in the same cycle with `sw=4'h7`, starting from EMPTY:
  - `a=b=4'h7`, `valid=1` on one edge.
- Press `btn_clr` and `btn_a` in the same cycle while in BOTH:
  - `a=b=0`, state EMPTY, `new_pair=0`.
- Debounce build with DEBOUNCE_CYCLES=16:
  - A 10-cycle glitch on `btn_b` causes no load.
  - A press held 20 cycles loads `b` once, on edge 19 after assertion.
- Additionally, assert `rst_n` low mid-press and confirm all outputs return to 0 asynchronously.
